// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module : mem_access_if
// Brief  : valid/ready request and single-cycle response bus for mem_access
// Rev    : 1.0
// ============================================================================
interface mem_access_if #(
  parameter int ADDR_W   = 15,
  parameter int MAX_SIZE = 3
);
  localparam int DATA_W = 8 << MAX_SIZE;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_fault;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_fault, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_fault, resp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module : mem_access (with spram)
// Brief  : big-endian 1/2/4/8-byte load/store sequencer over a 16-bit SPRAM
// Rev    : 1.0
// ============================================================================

// 16-bit single-port RAM with nibble write mask and registered read data.
module spram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   data_i,
  input  logic [3:0]    we_i,
  output logic [15:0]   data_o
);
  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (we_i[n]) mem[addr_i][4*n +: 4] <= data_i[4*n +: 4];
    end
    data_o <= mem[addr_i];
  end
endmodule

module mem_access #(
  parameter int ADDR_W   = 15,
  parameter int MAX_SIZE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_access_if.slave bus
);
  localparam int DATA_W = 8 << MAX_SIZE;
  localparam int CNT_W  = (MAX_SIZE > 1) ? MAX_SIZE - 1 : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FAULTCHK = 3'd1,
    S_BEAT     = 3'd2,
    S_DRAIN    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_fault_q, resp_fault_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              fault;
  logic              is_byte;
  logic [CNT_W-1:0]  last_beat;
  logic [ADDR_W-1:0] align_mask;
  logic [ADDR_W-2:0] spram_addr;
  logic [15:0]       din;
  logic [15:0]       dout;
  logic [15:0]       half_rd;
  logic [7:0]        byte_rd;
  logic [3:0]        spram_we;

  // sdata_q is the store value left-aligned, so the next beat is always its top bits.
  always_comb begin
    align_mask = ~({ADDR_W{1'b1}} << size_q);
    fault      = ((addr_q & align_mask) != '0) || (int'(size_q) > MAX_SIZE);
    is_byte    = (size_q == 2'd0);
    last_beat  = is_byte ? '0 : CNT_W'((32'd1 << size_q) / 2 - 1);
    spram_addr = addr_q[ADDR_W-1:1] + (ADDR_W-1)'(beat_q);
    half_rd    = {dout[7:0], dout[15:8]};
    byte_rd    = addr_q[0] ? dout[15:8] : dout[7:0];
    din        = is_byte ? {2{sdata_q[DATA_W-1 -: 8]}}
                         : {sdata_q[DATA_W-9 -: 8], sdata_q[DATA_W-1 -: 8]};
    spram_we   = 4'b0000;
    if (state_q == S_BEAT && write_q) begin
      spram_we = is_byte ? (addr_q[0] ? 4'b1100 : 4'b0011) : 4'b1111;
    end
    spram_we = spram_we & {4{rst_n}};
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    beat_d       = beat_q;
    acc_d        = acc_q;
    resp_valid_d = 1'b0;
    resp_fault_d = resp_fault_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          addr_d  = bus.req_addr;
          sdata_d = bus.req_wdata;
          state_d = S_FAULTCHK;
        end
      end
      S_FAULTCHK: begin
        beat_d  = '0;
        acc_d   = '0;
        sdata_d = sdata_q << (DATA_W - (8 << size_q));
        if (fault) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        // Data from the previous beat arrives while this beat is being issued.
        if (!write_q && beat_q != '0) acc_d = (acc_q << 16) | DATA_W'(half_rd);
        sdata_d = sdata_q << 16;
        beat_d  = beat_q + CNT_W'(1);
        if (beat_q == last_beat) begin
          beat_d = '0;
          if (write_q) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b0;
            resp_rdata_d = '0;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        acc_d        = is_byte ? DATA_W'(byte_rd) : ((acc_q << 16) | DATA_W'(half_rd));
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_rdata_d = acc_d;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      sdata_q      <= '0;
      beat_q       <= '0;
      acc_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      sdata_q      <= sdata_d;
      beat_q       <= beat_d;
      acc_q        <= acc_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_rdata = resp_rdata_q;

  spram #(
    .AW(ADDR_W - 1)
  ) u_spram (
    .clk    (clk),
    .addr_i (spram_addr),
    .data_i (din),
    .we_i   (spram_we),
    .data_o (dout)
  );
endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access
// Brief  : self-checking bench for mem_access against a byte-array memory model
// Rev    : 1.0
// ============================================================================
module tb_mem_access;
  localparam int ADDR_W   = 15;
  localparam int MAX_SIZE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(ADDR_W), .MAX_SIZE(MAX_SIZE)) bus ();

  mem_access #(.ADDR_W(ADDR_W), .MAX_SIZE(MAX_SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int we_viol   = 0;
  int resp_viol = 0;
  bit no_we   = 1'b0;
  bit no_resp = 1'b0;

  logic [7:0] ref_mem [0:(1<<ADDR_W)-1];

  typedef struct {
    bit          wr;
    int          size;
    int          addr;
    logic [63:0] wdata;
    bit          exp_f;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[17];

  always @(negedge clk) begin
    if (no_we && dut.spram_we != 4'b0000) we_viol <= we_viol + 1;
    if (no_resp && bus.resp_valid) resp_viol <= resp_viol + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain byte-addressed memory, big-endian multi-byte values.
  function automatic void model_access(input bit wr, input int size, input int addr,
                                       input logic [63:0] wdata,
                                       output bit f, output logic [63:0] rd);
    int n;
    n  = 1 << size;
    f  = (size > MAX_SIZE) || (addr % n != 0);
    rd = '0;
    if (f) return;
    for (int i = 0; i < n; i++) begin
      if (wr) ref_mem[addr+i] = wdata[8*(n-1-i) +: 8];
      else    rd = (rd << 8) | 64'(ref_mem[addr+i]);
    end
  endfunction

  function automatic int exp_lat(input bit wr, input int size, input bit f);
    int m;
    if (f) return 2;
    m = (size == 0) ? 1 : (1 << size) / 2;
    return wr ? m + 2 : m + 3;
  endfunction

  task automatic run_req(input bit wr, input int size, input int addr, input logic [63:0] wdata,
                         output bit got_f, output logic [63:0] got_rd,
                         output int lat, output bit rok);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = 2'(size);
    bus.req_addr  = 15'(addr);
    bus.req_wdata = wdata;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = ~bus.req_addr;
    bus.req_wdata = ~wdata;
    lat = 1;
    rok = 1'b1;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      if (bus.req_ready !== 1'b0) rok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.req_ready !== 1'b0) rok = 1'b0;
    got_f  = bus.resp_fault;
    got_rd = bus.resp_rdata;
    @(negedge clk);
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) rok = 1'b0;
    if (bus.resp_rdata !== got_rd || bus.resp_fault !== got_f) rok = 1'b0;
  endtask

  task automatic exec(input string nm, input bit wr, input int size, input int addr,
                      input logic [63:0] wdata, input bit ef, input logic [63:0] erd);
    bit          f;
    bit          rok;
    logic [63:0] rd;
    int          lat;
    no_we = ef;
    run_req(wr, size, addr, wdata, f, rd, lat, rok);
    no_we = 1'b0;
    check({nm, "_fault"}, 64'(f), 64'(ef));
    check({nm, "_rdata"}, rd, erd);
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat(wr, size, ef)));
    check({nm, "_ready_hold"}, 64'(rok), 64'd1);
  endtask

  initial begin
    bit          mf;
    logic [63:0] mrd;
    logic [63:0] d1;
    bit          rwr;
    int          rsize;
    int          raddr;
    int          n;
    logic [63:0] rdat;

    vecs[0]  = '{1'b1, 3, 'h10, 64'h0123456789ABCDEF, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 3, 'h10, 64'h0,                1'b0, 64'h0123456789ABCDEF};
    vecs[2]  = '{1'b0, 0, 'h10, 64'h0,                1'b0, 64'h01};
    vecs[3]  = '{1'b0, 0, 'h17, 64'h0,                1'b0, 64'hEF};
    vecs[4]  = '{1'b0, 1, 'h12, 64'h0,                1'b0, 64'h4567};
    vecs[5]  = '{1'b0, 2, 'h14, 64'h0,                1'b0, 64'h89ABCDEF};
    vecs[6]  = '{1'b1, 0, 'h12, 64'hFFFFFFFFFFFFFFAA, 1'b0, 64'h0};
    vecs[7]  = '{1'b0, 2, 'h10, 64'h0,                1'b0, 64'h0123AA67};
    vecs[8]  = '{1'b1, 0, 'h13, 64'h00000000000000BB, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 2, 'h10, 64'h0,                1'b0, 64'h0123AABB};
    vecs[10] = '{1'b0, 2, 'h06, 64'h0,                1'b1, 64'h0};
    vecs[11] = '{1'b1, 1, 'h11, 64'h5555,             1'b1, 64'h0};
    vecs[12] = '{1'b0, 3, 'h10, 64'h0,                1'b0, 64'h0123AABB89ABCDEF};
    vecs[13] = '{1'b1, 1, 'h20, 64'h12345678DEADBEEF, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 1, 'h20, 64'h0,                1'b0, 64'hBEEF};
    vecs[15] = '{1'b0, 3, 'h14, 64'h0,                1'b1, 64'h0};
    vecs[16] = '{1'b0, 0, 'h21, 64'h0,                1'b0, 64'hEF};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Power-on reset state
    no_we = 1'b1;
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_fault", 64'(bus.resp_fault), 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_we = 1'b0;

    for (int i = 0; i < 17; i++) begin
      model_access(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, mf, mrd);
      exec($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].addr,
           vecs[i].wdata, vecs[i].exp_f, vecs[i].exp_rd);
    end

    // Back-to-back with req_valid held high; wdata changes after acceptance.
    d1 = 64'h1122334455667788;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd3;
    bus.req_addr  = 15'h40;
    bus.req_wdata = d1;
    check("b2b_idle_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_size  = 2'd2;
    bus.req_addr  = 15'h48;
    bus.req_wdata = 64'hCAFEF00DA5A55A5A;
    n = 1;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_latency", 64'(n), 64'd6);
    @(negedge clk);
    check("b2b_second_accept_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = '0;
    n = 1;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_latency", 64'(n), 64'd4);
    check("b2b_second_fault", 64'(bus.resp_fault), 64'd0);
    model_access(1'b1, 3, 'h40, d1, mf, mrd);
    model_access(1'b1, 2, 'h48, 64'hCAFEF00DA5A55A5A, mf, mrd);
    exec("b2b_load_first", 1'b0, 3, 'h40, 64'h0, 1'b0, d1);
    exec("b2b_load_second", 1'b0, 2, 'h48, 64'h0, 1'b0, 64'hA5A55A5A);

    // Reset during beat 2 of an 8-byte store.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd3;
    bus.req_addr  = 15'h80;
    bus.req_wdata = 64'hFEEDFACE0BADC0DE;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    no_resp = 1'b1;
    no_we   = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("midrst_ready", 64'(bus.req_ready), 64'd1);
    check("midrst_valid", 64'(bus.resp_valid), 64'd0);
    check("midrst_fault", 64'(bus.resp_fault), 64'd0);
    check("midrst_rdata", bus.resp_rdata, 64'd0);
    check("midrst_we", 64'(dut.spram_we), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_we = 1'b0;
    @(negedge clk);
    check("postrst_ready", 64'(bus.req_ready), 64'd1);
    repeat (6) @(negedge clk);
    no_resp = 1'b0;
    model_access(1'b1, 3, 'h88, 64'h0F1E2D3C4B5A6978, mf, mrd);
    exec("postrst_store", 1'b1, 3, 'h88, 64'h0F1E2D3C4B5A6978, 1'b0, 64'h0);
    exec("postrst_load", 1'b0, 3, 'h88, 64'h0, 1'b0, 64'h0F1E2D3C4B5A6978);
    model_access(1'b0, 3, 'h10, 64'h0, mf, mrd);
    exec("postrst_intact", 1'b0, 3, 'h10, 64'h0, mf, mrd);

    // Randomized traffic in a pre-filled region against the model.
    for (int i = 0; i < 32; i++) begin
      rdat = {$urandom, $urandom};
      model_access(1'b1, 3, 'h100 + 8*i, rdat, mf, mrd);
      exec($sformatf("fill%0d", i), 1'b1, 3, 'h100 + 8*i, rdat, mf, mrd);
    end
    for (int i = 0; i < 120; i++) begin
      rwr   = 1'($urandom_range(0, 1));
      rsize = int'($urandom_range(0, 3));
      raddr = 'h100 + int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) raddr = raddr & ~((1 << rsize) - 1);
      if (raddr + (1 << rsize) > 'h200) raddr = 'h200 - (1 << rsize);
      rdat = {$urandom, $urandom};
      model_access(rwr, rsize, raddr, rdat, mf, mrd);
      exec($sformatf("rnd%0d", i), rwr, rsize, raddr, rdat, mf, mrd);
    end

    check("we_during_fault_or_reset", 64'(we_viol), 64'd0);
    check("resp_during_reset", 64'(resp_viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
